// File: rtl/jks_pkg.sv
// Shared types, constants and helpers for join_any_kill_sched.
//   state_e      : scheduler FSM states
//   LFSR_W/POLY  : width and right-shift Galois tap mask of the victim LFSR
//   popcount     : number of set bits in a 16-bit vector
//   kth_set_bit  : index of the k-th set bit (counting from bit 0)
//   mod_small    : x mod n for a 16-bit x and 1 <= n <= 16
package jks_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        SELECT = 3'd2,
        DRAIN  = 3'd3,
        FIN    = 3'd4
    } state_e;

    localparam int          LFSR_W    = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 for a right-shifting Galois LFSR
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // Returns 0 when fewer than k+1 bits are set; callers only ask for
    // k < popcount(v).
    function automatic logic [3:0] kth_set_bit(input logic [15:0] v, input logic [3:0] k);
        logic [3:0] cnt;
        logic [3:0] res;
        cnt = '0;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                if (cnt == k) begin
                    res = 4'(i);
                end
                cnt = cnt + 4'd1;
            end
        end
        return res;
    endfunction

    // Restoring long division, one compare/subtract stage per dividend bit.
    // The remainder stays below n <= 16, so a shifted remainder fits 6 bits.
    function automatic logic [3:0] mod_small(input logic [15:0] x, input logic [4:0] n);
        logic [5:0] rem;
        rem = '0;
        for (int i = 15; i >= 0; i--) begin
            rem = {rem[4:0], x[i]};
            if (rem >= {1'b0, n}) begin
                rem = rem - {1'b0, n};
            end
        end
        return (n == 5'd0) ? 4'd0 : rem[3:0];
    endfunction

endpackage

// File: rtl/jks_lfsr.sv
// 16-bit right-shifting Galois LFSR used to pick the kill victim.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads SEED
//   en    : advance one step when high
//   lfsr  : current LFSR state
// SEED must be nonzero, otherwise the register locks at zero.
module jks_lfsr
    import jks_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/join_any_kill_sched.sv
// Fork / join_any / kill-one-survivor job scheduler.
// Launches NUM_JOBS countdown jobs on start, latches the first finisher,
// kills one of the jobs still running, lets the rest drain, then pulses done.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : launch request, honoured only in IDLE
//   delay       : NUM_JOBS packed DLY_W-bit latencies, job i at [i*DLY_W +: DLY_W]
//   abort       : kill every job and return to IDLE (any non-IDLE state)
//   busy        : high whenever the scheduler is not IDLE
//   job_active  : per-job running flags
//   job_done    : one-cycle pulse per naturally finishing job
//   first_id    : lowest index among the first finishers, held
//   kill_valid  : one-cycle pulse when a victim is killed
//   kill_id     : victim index, held until overwritten
//   done        : one-cycle pulse at the end of a normal run
// Build option: JKS_RANDOM_KILL_EN selects the victim with an LFSR; without
// it the lowest-index surviving job is killed.
module join_any_kill_sched
    import jks_pkg::*;
#(
    parameter int          NUM_JOBS  = 3,
    parameter int          DLY_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         IDW       = $clog2(NUM_JOBS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NUM_JOBS*DLY_W-1:0] delay,
    input  logic                      abort,
    output logic                      busy,
    output logic [NUM_JOBS-1:0]       job_active,
    output logic [NUM_JOBS-1:0]       job_done,
    output logic [IDW-1:0]            first_id,
    output logic                      kill_valid,
    output logic [IDW-1:0]            kill_id,
    output logic                      done
);

    state_e                state_q, state_d;
    logic [NUM_JOBS-1:0]   job_active_q, job_active_d;
    logic [NUM_JOBS-1:0]   job_done_q, job_done_d;
    logic [IDW-1:0]        first_id_q, first_id_d;
    logic [IDW-1:0]        kill_id_q, kill_id_d;
    logic                  kill_valid_q, kill_valid_d;
    logic                  done_q, done_d;
    logic                  busy_q;

    logic                  load_w;
    logic                  clear_w;
    logic                  counting_w;
    logic [NUM_JOBS-1:0]   finish_w;
    logic [NUM_JOBS-1:0]   cand_w;
    logic [4:0]            cand_n_w;
    logic [3:0]            kth_w;
    logic [IDW-1:0]        victim_w;
    logic [IDW-1:0]        lowest_fin_w;

    assign load_w     = (state_q == IDLE) && start;
    assign clear_w    = (state_q != IDLE) && abort;
    assign counting_w = ((state_q == RUN) || (state_q == SELECT) || (state_q == DRAIN)) && !abort;

    // Per-job countdown. A job finishes on the edge where its counter steps
    // from 1 to 0; finish_w flags that edge one cycle ahead.
    for (genvar gi = 0; gi < NUM_JOBS; gi++) begin : g_job
        logic [DLY_W-1:0] cnt_q;
        logic [DLY_W-1:0] cnt_d;
        logic [DLY_W-1:0] dly_w;

        assign dly_w        = delay[gi*DLY_W +: DLY_W];
        assign finish_w[gi] = counting_w && job_active_q[gi] && (cnt_q == DLY_W'(1));

        always_comb begin
            cnt_d = cnt_q;
            if (load_w) begin
                // A zero delay still takes one cycle
                cnt_d = (dly_w == '0) ? DLY_W'(1) : dly_w;
            end else if (clear_w) begin
                cnt_d = '0;
            end else if (counting_w && job_active_q[gi]) begin
                cnt_d = cnt_q - DLY_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Kill candidates exclude jobs that finish naturally on this same edge.
    assign cand_w       = job_active_q & ~finish_w;
    assign cand_n_w     = popcount(16'(cand_w));
    assign lowest_fin_w = IDW'(kth_set_bit(16'(finish_w), 4'd0));
    assign victim_w     = IDW'(kth_set_bit(16'(cand_w), kth_w));

`ifdef JKS_RANDOM_KILL_EN
    logic [LFSR_W-1:0] lfsr_w;

    jks_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .lfsr  (lfsr_w)
    );

    assign kth_w = mod_small(lfsr_w, cand_n_w);
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign kth_w       = 4'd0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (|finish_w) state_d = SELECT;
            SELECT:  if (abort) state_d = IDLE;
                     else if (cand_n_w == 5'd0) state_d = FIN;
                     else state_d = DRAIN;
            DRAIN:   if (abort) state_d = IDLE;
                     else if (job_active_q == '0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output / datapath logic, registered below
    always_comb begin
        job_active_d = job_active_q;
        job_done_d   = '0;
        first_id_d   = first_id_q;
        kill_id_d    = kill_id_q;
        kill_valid_d = 1'b0;
        done_d       = 1'b0;

        if (load_w) begin
            job_active_d = '1;
        end else if (clear_w) begin
            job_active_d = '0;
        end else begin
            job_done_d   = finish_w;
            job_active_d = job_active_q & ~finish_w;
            if ((state_q == RUN) && (|finish_w)) begin
                first_id_d = lowest_fin_w;
            end
            if ((state_q == SELECT) && (cand_n_w != 5'd0)) begin
                kill_valid_d           = 1'b1;
                kill_id_d              = victim_w;
                job_active_d[victim_w] = 1'b0;
            end
            if (state_q == FIN) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_active_q <= '0;
            job_done_q   <= '0;
            first_id_q   <= '0;
            kill_id_q    <= '0;
            kill_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            job_active_q <= job_active_d;
            job_done_q   <= job_done_d;
            first_id_q   <= first_id_d;
            kill_id_q    <= kill_id_d;
            kill_valid_q <= kill_valid_d;
            done_q       <= done_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign busy       = busy_q;
    assign job_active = job_active_q;
    assign job_done   = job_done_q;
    assign first_id   = first_id_q;
    assign kill_valid = kill_valid_q;
    assign kill_id    = kill_id_q;
    assign done       = done_q;

endmodule

// File: tb/tb_join_any_kill_sched.sv
// Self-checking bench for join_any_kill_sched (NUM_JOBS=3, DLY_W=8).
// Table vectors feed an event scoreboard; abort, start-while-busy and
// asynchronous reset are exercised by hand-written sequences.
module tb_join_any_kill_sched;

    localparam int NJ = 3;
    localparam int DW = 8;
    localparam int IW = 2;

    localparam int EV_JD   = 0;
    localparam int EV_KILL = 1;
    localparam int EV_DONE = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NJ*DW-1:0] delay = '0;
    logic             busy;
    logic [NJ-1:0]    job_active;
    logic [NJ-1:0]    job_done;
    logic [IW-1:0]    first_id;
    logic             kill_valid;
    logic [IW-1:0]    kill_id;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    // d*: delays, f*: expected finish cycle (-1 = never), first: first_id,
    // kcyc/kid: kill cycle and victim (kcyc -1 = no kill), dcyc: done cycle
    typedef struct {
        int d0, d1, d2;
        int f0, f1, f2;
        int first;
        int kcyc, kid;
        int dcyc;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    join_any_kill_sched #(
        .NUM_JOBS  (NJ),
        .DLY_W     (DW),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .delay      (delay),
        .abort      (abort),
        .busy       (busy),
        .job_active (job_active),
        .job_done   (job_done),
        .first_id   (first_id),
        .kill_valid (kill_valid),
        .kill_id    (kill_id),
        .done       (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_job_active"}, int'(job_active), 0);
        check({tag, "_job_done"}, int'(job_done), 0);
        check({tag, "_first_id"}, int'(first_id), 0);
        check({tag, "_kill_valid"}, int'(kill_valid), 0);
        check({tag, "_kill_id"}, int'(kill_id), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Drives start into edge T0 and returns #1 after it.
    task automatic drive_start(input int d0, input int d1, input int d2);
        logic [DW-1:0] b0, b1, b2;
        b0 = DW'(d0);
        b1 = DW'(d1);
        b2 = DW'(d2);
        @(negedge clk);
        delay = {b2, b1, b0};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("active_at_T0", int'(job_active), 7);
        check("busy_at_T0", int'(busy), 1);
    endtask

    task automatic push_expected(input vec_t v);
        int jd;
        for (int c = 1; c <= v.dcyc; c++) begin
            jd = 0;
            if (v.f0 == c) jd = jd | 1;
            if (v.f1 == c) jd = jd | 2;
            if (v.f2 == c) jd = jd | 4;
            if (jd != 0) exp_q.push_back('{c, EV_JD, jd});
            if (c == v.kcyc) exp_q.push_back('{c, EV_KILL, v.kid});
            if (c == v.dcyc) exp_q.push_back('{c, EV_DONE, 0});
        end
    endtask

    task automatic match_ev(input int c, input int kind, input int val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got cyc=%0d kind=%0d val=%0d, none expected", c, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != c || e.kind != kind || e.val != val) begin
                n_bad++;
                $display("FAIL event: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         c, kind, val, e.cyc, e.kind, e.val);
            end
        end
    endtask

    // Watches the DUT after T0 until done or budget expiry.
    task automatic run_scoreboard(input int budget, input int exp_first);
        int got_done;
        got_done = 0;
        for (int c = 1; c <= budget && got_done == 0; c++) begin
            @(posedge clk);
            #1;
            if (job_done != '0) match_ev(c, EV_JD, int'(job_done));
            if (kill_valid)     match_ev(c, EV_KILL, int'(kill_id));
            if (done) begin
                match_ev(c, EV_DONE, 0);
                got_done = 1;
                check("busy_at_done", int'(busy), 0);
                check("first_id", int'(first_id), exp_first);
            end
        end
        if (got_done == 0) check("done_timeout", 0, 1);
        check("missing_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int ok;
        ok = 0;
        for (int c = 0; c < budget && ok == 0; c++) begin
            @(posedge clk);
            #1;
            if (!busy) ok = 1;
        end
        if (ok == 0) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int kid;
        int mask;
        int seen1;
        int seen2;

        vecs[0] = '{10, 20, 30,  10, -1, 30,  0, 11, 1, 32};
        vecs[1] = '{ 5,  5,  9,   5,  5, -1,  0,  6, 2,  8};
        vecs[2] = '{ 7,  7,  7,   7,  7,  7,  0, -1, 0,  9};
        vecs[3] = '{ 0,  4,  4,   1, -1,  4,  0,  2, 1,  6};
        vecs[4] = '{20,  3, 15,  -1,  3, 15,  1,  4, 0, 17};
        vecs[5] = '{ 6,  2,  3,  -1,  2,  3,  1,  3, 0,  5};
        vecs[6] = '{ 4,  9,  4,   4, -1,  4,  0,  5, 1,  7};

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("idle");

`ifndef JKS_RANDOM_KILL_EN
        for (int i = 0; i < 7; i++) begin
            drive_start(vecs[i].d0, vecs[i].d1, vecs[i].d2);
            push_expected(vecs[i]);
            run_scoreboard(vecs[i].dcyc + 10, vecs[i].first);
            $display("vec %0d delays %0d/%0d/%0d checked", i, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            @(posedge clk);
        end
`else
        seen1 = 0;
        seen2 = 0;
        for (int r = 0; r < 200; r++) begin
            drive_start(10, 20, 30);
            kid  = -1;
            mask = 0;
            for (int c = 1; c <= 40 && !done; c++) begin
                @(posedge clk);
                #1;
                if (kill_valid) begin
                    kid = int'(kill_id);
                    check("rand_kill_cycle", c, 11);
                end
                mask = mask | int'(job_done);
            end
            check("rand_done_seen", int'(done), 1);
            check("rand_kill_range", int'(kid == 1 || kid == 2), 1);
            check("rand_done_mask", mask, (kid == 1) ? 5 : 3);
            if (kid == 1) seen1++;
            if (kid == 2) seen2++;
            $display("rand run %0d kill_id %0d job_done mask %0d", r, kid, mask);
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        check("rand_saw_kill1", int'(seen1 > 0), 1);
        check("rand_saw_kill2", int'(seen2 > 0), 1);
`endif

        // Abort mid-run, with a start request while busy that must be ignored
        drive_start(10, 20, 30);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) begin
                delay = {8'd3, 8'd3, 8'd3};
                start = 1'b1;
            end
            if (c == 6) start = 1'b0;
            if (c == 8)  check("busy_start_ignored_jd", int'(job_done), 0);
            if (c == 10) check("abort_seq_jd0", int'(job_done), 1);
            if (c == 11) check("abort_seq_kill", int'(kill_valid), 1);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_job_active", int'(job_active), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_job_done", int'(job_done), 0);
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done || kill_valid || job_done != '0) pulses++;
        end
        check("abort_no_pulses", pulses, 0);
        $display("abort sequence checked");

`ifndef JKS_RANDOM_KILL_EN
        drive_start(vecs[0].d0, vecs[0].d1, vecs[0].d2);
        push_expected(vecs[0]);
        run_scoreboard(vecs[0].dcyc + 10, vecs[0].first);
        $display("restart after abort checked");
`else
        drive_start(10, 20, 30);
        wait_idle(50);
        $display("restart after abort checked");
`endif

        // Asynchronous reset in DRAIN, then a zero-delay run
        drive_start(10, 20, 30);
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");

`ifndef JKS_RANDOM_KILL_EN
        drive_start(vecs[3].d0, vecs[3].d1, vecs[3].d2);
        push_expected(vecs[3]);
        run_scoreboard(vecs[3].dcyc + 10, vecs[3].first);
`else
        drive_start(0, 4, 4);
        @(posedge clk);
        #1;
        check("zero_delay_jd0", int'(job_done), 1);
        wait_idle(20);
`endif
        $display("reset and zero-delay sequence checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
